// File: rtl/pc_npc_sequencer.sv
// Next-PC controller for the fetch-stage PC/nPC pair: delayed branches, annul, stalls, boot hold.
// Optional trap redirect is compiled in when PCSEQ_EXC_EN is defined.
module pc_npc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] RESET_NPC   = 32'h0000_0004,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_q,
  input  logic [31:0] npc_q,
  input  logic        stall_req,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  output logic [31:0] pc_d,
  output logic [31:0] npc_d,
  output logic        pc_le,
  output logic        npc_le,
  output logic        if_flush,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic [7:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold
`ifdef PCSEQ_EXC_EN
    , StExc
`endif
  } state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  state_e      r_state;
  logic [3:0]  r_boot_cnt;
  logic        r_fetch_valid;
  logic [31:0] r_epc;
  logic [7:0]  r_stall_cnt;

  logic w_active;
  logic w_exc_take;
  logic w_go;

  assign w_active = (r_state == StRun) || (r_state == StHold);

`ifdef PCSEQ_EXC_EN
  // A trap overrides any stall and any pending branch/jump.
  assign w_exc_take = w_active & exc_req;
`else
  assign w_exc_take = 1'b0;
  logic w_unused;
  assign w_unused = exc_req ^ (^pc_q) ^ (^EXC_VECTOR);
`endif

  assign w_go = w_active & ~stall_req & ~w_exc_take;

  always_comb begin
    pc_d     = npc_q;
    npc_d    = npc_q + 32'd4;
    pc_le    = 1'b0;
    npc_le   = 1'b0;
    if_flush = 1'b0;
    case (r_state)
      StBoot: begin
        // Keep the D inputs at the reset values while the registers are held.
        pc_d  = RESET_PC;
        npc_d = RESET_NPC;
      end
`ifdef PCSEQ_EXC_EN
      StExc: if_flush = 1'b1;
`endif
      default: begin
        if (w_exc_take) begin
          pc_d     = EXC_VECTOR;
          npc_d    = EXC_VECTOR + 32'd4;
          pc_le    = 1'b1;
          npc_le   = 1'b1;
          if_flush = 1'b1;
        end else if (w_go) begin
          pc_le  = 1'b1;
          npc_le = 1'b1;
          if (jmp_valid) begin
            npc_d = jmp_target;
          end else if (br_valid && br_taken) begin
            npc_d = br_target;
          end else begin
            // Not-taken annulling branch squashes the delay slot already in IF.
            if_flush = br_valid & br_annul;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= StBoot;
      r_boot_cnt    <= 4'd0;
      r_fetch_valid <= 1'b0;
      r_epc         <= 32'd0;
      r_stall_cnt   <= 8'd0;
    end else begin
      case (r_state)
        StBoot: begin
          if (r_boot_cnt == BootLast) begin
            r_state       <= StRun;
            r_fetch_valid <= 1'b1;
          end else begin
            r_boot_cnt <= r_boot_cnt + 4'd1;
          end
        end
        StRun, StHold: begin
          if (w_exc_take) begin
`ifdef PCSEQ_EXC_EN
            r_state       <= StExc;
            r_fetch_valid <= 1'b0;
            r_epc         <= pc_q;
`endif
          end else if (stall_req) begin
            r_state       <= StHold;
            r_fetch_valid <= 1'b0;
            if (r_stall_cnt != 8'hFF) r_stall_cnt <= r_stall_cnt + 8'd1;
          end else begin
            r_state       <= StRun;
            r_fetch_valid <= 1'b1;
          end
        end
        default: begin
          r_state       <= StRun;
          r_fetch_valid <= 1'b1;
        end
      endcase
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign epc         = r_epc;
  assign stall_cnt   = r_stall_cnt;

endmodule
